// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - register-file write-back FIFO with read-port forwarding
module writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ready,
  input  logic          hold,
  output logic          rf_WE,
  output logic [AW-1:0] rf_WriteReg,
  output logic [DW-1:0] rf_WriteData,
  input  logic [AW-1:0] AReg,
  input  logic [AW-1:0] BReg,
  input  logic [DW-1:0] rf_Aout,
  input  logic [DW-1:0] rf_Bout,
  output logic [DW-1:0] Aout,
  output logic [DW-1:0] Bout,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] reg_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

  // A full buffer refuses pushes even when it drains in the same cycle.
  assign wb_ready = reset_n & (count_q != FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;

  assign rf_WE        = reset_n & ~empty & ~hold;
  assign rf_WriteReg  = reg_q[rd_ptr_q];
  assign rf_WriteData = data_q[rd_ptr_q];

  assign push = wb_valid & wb_ready;
  assign pop  = rf_WE;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is never cleared; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[wr_ptr_q]  <= wb_reg;
      data_q[wr_ptr_q] <= wb_data;
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [PW-1:0] idx;
    Aout = rf_Aout;
    Bout = rf_Bout;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (reg_q[idx] == AReg) begin
          Aout = data_q[idx];
        end
        if (reg_q[idx] == BReg) begin
          Bout = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// tb/tb_writeback_buffer.sv - scoreboard bench for writeback_buffer
module tb_writeback_buffer;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wb_valid;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          wb_ready;
  logic          hold;
  logic          rf_WE;
  logic [AW-1:0] rf_WriteReg;
  logic [DW-1:0] rf_WriteData;
  logic [AW-1:0] AReg;
  logic [AW-1:0] BReg;
  logic [DW-1:0] rf_Aout;
  logic [DW-1:0] rf_Bout;
  logic [DW-1:0] Aout;
  logic [DW-1:0] Bout;
  logic [2:0]    count;
  logic          empty;

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  writeback_buffer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .hold         (hold),
    .rf_WE        (rf_WE),
    .rf_WriteReg  (rf_WriteReg),
    .rf_WriteData (rf_WriteData),
    .AReg         (AReg),
    .BReg         (BReg),
    .rf_Aout      (rf_Aout),
    .rf_Bout      (rf_Bout),
    .Aout         (Aout),
    .Bout         (Bout),
    .count        (count),
    .empty        (empty)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] idx, input logic [DW-1:0] rf);
    logic [DW-1:0] v;
    v = rf;
    foreach (sb_q[i]) begin
      if (sb_q[i].r == idx) v = sb_q[i].d;
    end
    return v;
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    logic exp_ready, exp_we, do_push;
    ent_t nxt;
    @(negedge clk);
    exp_ready = reset_n && (sb_q.size() < DEPTH);
    exp_we    = reset_n && (sb_q.size() != 0) && !hold;
    check_val("wb_ready", 32'(wb_ready), 32'(exp_ready));
    check_val("rf_WE", 32'(rf_WE), 32'(exp_we));
    if (exp_we) begin
      check_val("rf_WriteReg", 32'(rf_WriteReg), 32'(sb_q[0].r));
      check_val("rf_WriteData", 32'(rf_WriteData), 32'(sb_q[0].d));
    end
    check_val("count", 32'(count), 32'(sb_q.size()));
    check_val("empty", 32'(empty), 32'(sb_q.size() == 0));
    check_val("Aout", 32'(Aout), 32'(fwd(AReg, rf_Aout)));
    check_val("Bout", 32'(Bout), 32'(fwd(BReg, rf_Bout)));
    do_push = wb_valid && exp_ready;
    nxt     = '{r: wb_reg, d: wb_data};
    @(posedge clk);
    if (!reset_n) begin
      sb_q.delete();
    end else begin
      if (exp_we) void'(sb_q.pop_front());
      if (do_push) sb_q.push_back(nxt);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d, input logic h);
    wb_valid = v;
    wb_reg   = r;
    wb_data  = d;
    hold     = h;
    cycle();
  endtask

  task automatic drain();
    int n;
    wb_valid = 1'b0;
    hold     = 1'b0;
    n        = 0;
    while (sb_q.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    cycle();
    check_val("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    reset_n  = 1'b0;
    wb_valid = 1'b0;
    wb_reg   = '0;
    wb_data  = '0;
    hold     = 1'b0;
    AReg     = '0;
    BReg     = '0;
    rf_Aout  = 16'h5a5a;
    rf_Bout  = 16'ha5a5;

    // Reset for two cycles, then empty-buffer forwarding sweep.
    cycle();
    cycle();
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      AReg    = AW'(i);
      BReg    = AW'(15 - i);
      rf_Aout = DW'($urandom);
      rf_Bout = DW'($urandom);
      cycle();
    end

    // Single write, exactly one cycle of latency to the register file.
    AReg    = 4'd3;
    rf_Aout = 16'h0000;
    drive(1'b1, 4'd3, 16'h1234, 1'b0);
    wb_valid = 1'b0;
    #1;
    check_val("t2_fwd", 32'(Aout), 32'h1234);
    check_val("t2_we", 32'(rf_WE), 32'd1);
    cycle();
    cycle();

    // Fill while held; fifth request refused.
    drive(1'b1, 4'd1, 16'd1, 1'b1);
    drive(1'b1, 4'd2, 16'd2, 1'b1);
    drive(1'b1, 4'd1, 16'd3, 1'b1);
    drive(1'b1, 4'd5, 16'd5, 1'b1);
    drive(1'b1, 4'd6, 16'd6, 1'b1);
    wb_valid = 1'b0;
    AReg     = 4'd1;
    BReg     = 4'd2;
    #1;
    check_val("t3_count", 32'(count), 32'd4);
    check_val("t3_ready", 32'(wb_ready), 32'd0);
    check_val("t3_A1", 32'(Aout), 32'd3);
    check_val("t3_B2", 32'(Bout), 32'd2);
    AReg    = 4'd6;
    rf_Aout = 16'hbeef;
    #1;
    check_val("t3_A6", 32'(Aout), 32'hbeef);
    drain();

    // Steady push+pop at count 2 with pointer wrap.
    drive(1'b1, 4'd7, 16'h0700, 1'b1);
    drive(1'b1, 4'd8, 16'h0800, 1'b1);
    for (int i = 0; i < 8; i++) begin
      AReg = AW'($urandom);
      BReg = AW'($urandom);
      drive(1'b1, AW'(i + 9), DW'(16'h1000 + i), 1'b0);
    end
    wb_valid = 1'b0;
    #1;
    check_val("t5_count", 32'(count), 32'd2);
    drain();

    // Reset discards pending entries; nothing is written afterwards.
    drive(1'b1, 4'd1, 16'haaaa, 1'b1);
    drive(1'b1, 4'd2, 16'hbbbb, 1'b1);
    drive(1'b1, 4'd3, 16'hcccc, 1'b1);
    wb_valid = 1'b0;
    reset_n  = 1'b0;
    cycle();
    reset_n = 1'b1;
    hold    = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check_val("t6_count", 32'(count), 32'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      AReg    = AW'($urandom);
      BReg    = AW'($urandom);
      rf_Aout = DW'($urandom);
      rf_Bout = DW'($urandom);
      drive(($urandom_range(0, 3) != 0), AW'($urandom), DW'($urandom), ($urandom_range(0, 2) == 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
